// File: rtl/phoenix_switch_control.sv
// Phoenix router switch control: arbitrates input routing requests, computes XY routes and
// tracks output allocation. Define PHOENIX_RR_ARB_EN for round-robin arbitration (default: fixed).

`ifndef TAM_FLIT
`define TAM_FLIT 16
`endif

module phoenix_switch_control #(
    parameter int unsigned FLIT_W = `TAM_FLIT
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [FLIT_W/2-1:0]   address,
    input  logic [4:0]            h,
    input  logic [4:0]            sender,
    input  logic [5*FLIT_W-1:0]   data,
    output logic [4:0]            ack_h,
    output logic [4:0]            free,
    output logic [14:0]           mux_in
);

    localparam int unsigned HalfW    = FLIT_W / 2;
    localparam int unsigned QuarterW = FLIT_W / 4;

    localparam logic [2:0] East  = 3'd0;
    localparam logic [2:0] West  = 3'd1;
    localparam logic [2:0] North = 3'd2;
    localparam logic [2:0] South = 3'd3;
    localparam logic [2:0] Local = 3'd4;

    typedef enum logic [1:0] {S_IDLE, S_ARB, S_ROUTE, S_ACK} state_e;

    state_e      state_q, state_d;
    logic [2:0]  sel_q, sel_d;
    logic [2:0]  target_q, target_d;
    logic [4:0]  free_q, free_d;
    logic [4:0]  seen_q, seen_d;
    logic [2:0]  mux_q [5];
    logic [2:0]  mux_d [5];

    logic [4:0]        req;
    logic              arb_found;
    logic [2:0]        arb_sel;
    logic              grant;
    logic [2:0]        route_target;
    logic [HalfW-1:0]  header [5];
    logic [HalfW-1:0]  sel_header;
    logic [QuarterW-1:0] dst_x, dst_y, loc_x, loc_y;

    // Only the address half of each head flit matters to routing.
    logic unused_data;
    assign unused_data = ^data;

    for (genvar i = 0; i < 5; i++) begin : g_header
        assign header[i] = data[i*FLIT_W +: HalfW];
    end

    // A buffer already streaming a packet must not win arbitration again.
    assign req = h & ~sender;

`ifdef PHOENIX_RR_ARB_EN
    logic [2:0] rr_q, rr_d;
    logic [2:0] rr_idx;

    always_comb begin
        arb_found = 1'b0;
        arb_sel   = East;
        rr_idx    = East;
        for (int k = 1; k <= 5; k++) begin
            rr_idx = 3'((int'(rr_q) + k) % 5);
            if (!arb_found && req[rr_idx]) begin
                arb_found = 1'b1;
                arb_sel   = rr_idx;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rr_q <= Local;
        end else begin
            rr_q <= rr_d;
        end
    end
`else
    always_comb begin
        arb_found = |req;
        if (req[Local]) begin
            arb_sel = Local;
        end else if (req[East]) begin
            arb_sel = East;
        end else if (req[West]) begin
            arb_sel = West;
        end else if (req[North]) begin
            arb_sel = North;
        end else begin
            arb_sel = South;
        end
    end
`endif

    // XY dimension-order routing on the selected header.
    assign sel_header = header[sel_q];
    assign dst_x      = sel_header[HalfW-1:QuarterW];
    assign dst_y      = sel_header[QuarterW-1:0];
    assign loc_x      = address[HalfW-1:QuarterW];
    assign loc_y      = address[QuarterW-1:0];

    always_comb begin
        if (dst_x > loc_x) begin
            route_target = East;
        end else if (dst_x < loc_x) begin
            route_target = West;
        end else if (dst_y > loc_y) begin
            route_target = North;
        end else if (dst_y < loc_y) begin
            route_target = South;
        end else begin
            route_target = Local;
        end
    end

    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        target_d = target_q;
        grant    = 1'b0;
`ifdef PHOENIX_RR_ARB_EN
        rr_d     = rr_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (h != 5'b0) begin
                    state_d = S_ARB;
                end
            end
            S_ARB: begin
                if (arb_found) begin
                    sel_d   = arb_sel;
                    state_d = S_ROUTE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ROUTE: begin
                // Registered free: a release landing this cycle is only seen on the retry.
                if (free_q[route_target]) begin
                    target_d = route_target;
                    state_d  = S_ACK;
                end else begin
`ifdef PHOENIX_RR_ARB_EN
                    rr_d    = sel_q;
`endif
                    state_d = S_IDLE;
                end
            end
            S_ACK: begin
                grant   = 1'b1;
`ifdef PHOENIX_RR_ARB_EN
                rr_d    = sel_q;
`endif
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output allocation: release needs the source seen sending, then seen idle.
    always_comb begin
        free_d = free_q;
        seen_d = seen_q;
        mux_d  = mux_q;
        for (int o = 0; o < 5; o++) begin
            if (!free_q[o]) begin
                if (sender[mux_q[o]]) begin
                    seen_d[o] = 1'b1;
                end else if (seen_q[o]) begin
                    free_d[o] = 1'b1;
                    seen_d[o] = 1'b0;
                end
            end
        end
        if (grant) begin
            free_d[target_q] = 1'b0;
            mux_d[target_q]  = sel_q;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= S_IDLE;
            sel_q    <= East;
            target_q <= East;
            free_q   <= 5'b11111;
            seen_q   <= 5'b00000;
            mux_q    <= '{default: 3'd0};
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            target_q <= target_d;
            free_q   <= free_d;
            seen_q   <= seen_d;
            mux_q    <= mux_d;
        end
    end

    always_comb begin
        ack_h = 5'b0;
        if (state_q == S_ACK && !reset) begin
            ack_h[sel_q] = 1'b1;
        end
    end

    always_comb begin
        mux_in = 15'b0;
        for (int o = 0; o < 5; o++) begin
            mux_in[o*3 +: 3] = mux_q[o];
        end
    end

    assign free = free_q;

endmodule

// File: doc/phoenix_switch_control.md
PHOENIX_SWITCH_CONTROL -- requirements
Module: phoenix_switch_control

Interface
REQ-001 The module SHALL have parameter FLIT_W, default `TAM_FLIT, the flit width in bits; a header flit carries the destination address in bits [FLIT_W/2-1:0].
REQ-002 The module SHALL have port clock  input  1  system clock; all state changes on its rising edge.
REQ-003 The module SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-004 The module SHALL have port address  input  FLIT_W/2  own router address; X = [FLIT_W/2-1:FLIT_W/4], Y = [FLIT_W/4-1:0].
REQ-005 The module SHALL have port h  input  5  per-input routing request from input buffers; index 0..4 = EAST, WEST, NORTH, SOUTH, LOCAL.
REQ-006 The module SHALL have port sender  input  5  per-input "packet in transfer" flag from input buffers.
REQ-007 The module SHALL have port data  input  5*FLIT_W  buffer head flits; input i occupies bits [i*FLIT_W +: FLIT_W].
REQ-008 The module SHALL have port ack_h  output  5  one-hot routing grant to input buffers.
REQ-009 The module SHALL have port free  output  5  per-output idle flag; 1 = output unallocated.
REQ-010 The module SHALL have port mux_in  output  15  crossbar select; output o is driven by input mux_in[o*3 +: 3].

Function
REQ-011 The FSM SHALL have states S_IDLE, S_ARB, S_ROUTE and S_ACK.
REQ-012 In S_IDLE with h != 0, the next state SHALL be S_ARB; otherwise the FSM SHALL remain in S_IDLE.
REQ-013 In S_ARB, the module SHALL latch sel = the first requesting input searching from (rr_ptr+1) mod 5 upward with wrap, and go to S_ROUTE.
REQ-014 In S_ROUTE, the module SHALL compute the target from the header data[sel] using XY order: dX > lX -> EAST; dX < lX -> WEST; else dY > lY -> NORTH; dY < lY -> SOUTH; else LOCAL (unsigned compares).
REQ-015 In S_ROUTE, if free[target] = 1, the next state SHALL be S_ACK with target latched; otherwise the FSM SHALL set rr_ptr = sel and return to S_IDLE with no ack.
REQ-016 In S_ACK, ack_h[sel] SHALL be 1 for exactly that one cycle; free[target] SHALL clear, mux_in[target] SHALL load sel, and rr_ptr SHALL load sel on the S_ACK->S_IDLE edge.
REQ-017 Latency: with h first seen in S_IDLE at cycle n, ack_h SHALL assert in cycle n+3 if no blocking occurs.
REQ-018 ack_h SHALL be all-zero in every state except S_ACK.
REQ-019 A per-output seen flag SHALL set when the output is busy and sender[mux_in[o]] = 1.
REQ-020 A busy output SHALL be released (free <= 1, seen <= 0) in the cycle after sender[src] = 0 with seen = 1; an output SHALL NOT be released before its sender has been observed high.
REQ-021 When a release and a grant check for the same output occur in the same cycle, S_ROUTE SHALL use the registered free value, so the grant blocks and is retried.
REQ-022 Multiple outputs SHALL be releasable in the same cycle, independent of FSM state.
REQ-023 h of an input that is currently sending SHALL be ignored by arbitration (requests are masked by sender).

Reset
REQ-024 While reset = 1, the state SHALL be S_IDLE, ack_h = 0, free = 5'b11111, mux_in = 0, seen = 0, and rr_ptr = 4, so EAST is searched first.
REQ-025 A reset asserted in S_ARB, S_ROUTE or S_ACK SHALL abort the pending grant with no ack_h pulse, and all outputs SHALL return to free.

Configuration
REQ-026 With PHOENIX_RR_ARB_EN defined, arbitration SHALL be round-robin as in REQ-013.
REQ-027 With PHOENIX_RR_ARB_EN undefined, arbitration SHALL use fixed priority LOCAL > EAST > WEST > NORTH > SOUTH, rr_ptr SHALL be absent, and all other behaviour SHALL be unchanged.

Verification
REQ-028 address=8'h11; h=5'b00001, data[EAST]=16'h0021 -> ack_h=5'b00001 three cycles later, free[EAST]=0, mux_in[EAST]=0.
REQ-029 After REQ-028, sender[0] goes 1 for 4 cycles then 0 -> free[EAST] returns to 1 exactly one cycle after sender falls.
REQ-030 RR defined; h=5'b10001 both held, both headers target distinct free outputs -> grant order EAST then LOCAL; repeated after release -> order alternates.
REQ-031 Two inputs target LOCAL (header 16'h0011): first granted; second blocked, no ack, while sender is high; second granted 3 cycles after the first's release.
REQ-032 reset pulsed during S_ROUTE -> no ack_h pulse, free = 5'b11111, mux_in = 0 the next cycle.
REQ-033 RR undefined; h=5'b11111 with all targets free -> LOCAL acked first.
